// File: rtl/capture_buffer.sv
// Triggered ADC frame capture: arms on request, triggers on a level crossing or
// timeout, fills a shadow bank and publishes it as a double-buffered frame.
module capture_buffer #(
  parameter int WIDTH   = 12,
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 1048576
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] trig_level,
  input  logic             trig_slope,
  input  logic             arm,
  output logic [WIDTH-1:0] frame_data [0:DEPTH-1],
  output logic             frame_ready,
  output logic             busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [IDX_W-1:0] idx_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] prev_r;
  logic             prev_ok_r;
  logic [WIDTH-1:0] shadow_r [0:DEPTH-1];

  logic level_hit_s;
  logic timed_out_s;
  logic trig_s;
  logic last_s;

  // Trigger detection and end-of-frame decode
  always_comb begin
    level_hit_s = 1'b0;
    if (trig_slope == 1'b0) begin
      level_hit_s = (prev_r < trig_level) && (sample >= trig_level);
    end else begin
      level_hit_s = (prev_r > trig_level) && (sample <= trig_level);
    end
    timed_out_s = (cnt_r >= TIMEOUT_CNT);
    trig_s      = (state_r == ARMED) && sample_valid &&
                  (timed_out_s || (prev_ok_r && level_hit_s));
    last_s      = (state_r == CAPTURE) && sample_valid && (idx_r == LAST_IDX);
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (arm) begin
          state_s = ARMED;
        end else begin
          state_s = IDLE;
        end
      end
      ARMED: begin
        if (trig_s) begin
          state_s = CAPTURE;
        end else begin
          state_s = ARMED;
        end
      end
      CAPTURE: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = CAPTURE;
        end
      end
      DONE: begin
        if (arm) begin
          state_s = ARMED;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register; busy is decoded from the next state so it lines up with state_r
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s == ARMED) || (state_s == CAPTURE);
    end
  end

  // Armed-phase history and timeout counter; both rest at zero outside ARMED
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_r    <= {WIDTH{1'b0}};
      prev_ok_r <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
    end else if (state_r != ARMED) begin
      prev_ok_r <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      if (!timed_out_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (sample_valid) begin
        prev_r    <= sample;
        prev_ok_r <= 1'b1;
      end
    end
  end

  // Shadow bank fill
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_r <= {IDX_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        shadow_r[i] <= {WIDTH{1'b0}};
      end
    end else if (trig_s) begin
      shadow_r[0] <= sample;
      idx_r       <= IDX_W'(1);
    end else if ((state_r == CAPTURE) && sample_valid) begin
      shadow_r[idx_r] <= sample;
      if (last_s) begin
        idx_r <= {IDX_W{1'b0}};
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end
  end

  // Published frame: the final sample bypasses the shadow so the copy is complete on DONE entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_ready <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        frame_data[i] <= {WIDTH{1'b0}};
      end
    end else if (last_s) begin
      frame_ready <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        frame_data[i] <= shadow_r[i];
      end
      frame_data[DEPTH-1] <= sample;
    end else if ((state_r == DONE) && arm) begin
      frame_ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_capture_buffer.sv
// Directed bench for capture_buffer: stimulus pushes expected frames into queues,
// monitors compare each published frame on the rising edge of frame_ready.
module tb_capture_buffer;

  localparam int W = 16;
  localparam int D = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, arm, arm_to, sample_valid, trig_slope;
  logic [W-1:0] sample, trig_level;
  logic [W-1:0] fd    [0:D-1];
  logic [W-1:0] fd_to [0:D-1];
  logic         fr, busy, fr_to, busy_to;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_to_q[$];
  logic [W-1:0] frame_a [0:D-1];

  int n_checks = 0;
  int n_fail   = 0;

  capture_buffer #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .trig_level(trig_level), .trig_slope(trig_slope), .arm(arm),
    .frame_data(fd), .frame_ready(fr), .busy(busy)
  );

  capture_buffer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(64)) u_dut_to (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .trig_level(trig_level), .trig_slope(trig_slope), .arm(arm_to),
    .frame_data(fd_to), .frame_ready(fr_to), .busy(busy_to)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic v, input logic [W-1:0] s);
    sample_valid = v;
    sample       = s;
    tick();
  endtask

  function automatic int nonzero_main();
    int n = 0;
    for (int i = 0; i < D; i++) if (fd[i] !== '0) n++;
    return n;
  endfunction

  function automatic int diff_frame_a();
    int n = 0;
    for (int i = 0; i < D; i++) if (fd[i] !== frame_a[i]) n++;
    return n;
  endfunction

  // Monitor for the main instance
  always @(negedge clk) begin : mon_main
    static logic fr_q = 1'b0;
    int bad, first;
    logic [W-1:0] e, a0;
    if (fr === 1'b1 && !fr_q) begin
      n_checks++;
      if (exp_q.size() < D) begin
        n_fail++;
        $display("FAIL main_unexpected_frame: got frame with %0d expected words queued, expected %0d", exp_q.size(), D);
      end else begin
        bad = 0; first = 0; e = '0; a0 = '0;
        for (int i = 0; i < D; i++) begin
          logic [W-1:0] x;
          x = exp_q.pop_front();
          if (fd[i] !== x) begin
            if (bad == 0) begin first = i; e = x; a0 = fd[i]; end
            bad++;
          end
        end
        if (bad != 0) begin
          n_fail++;
          $display("FAIL main_frame: %0d words differ, first [%0d] got %0d expected %0d", bad, first, a0, e);
        end
      end
    end
    fr_q = (fr === 1'b1);
  end

  // Monitor for the short-timeout instance
  always @(negedge clk) begin : mon_to
    static logic fr_q = 1'b0;
    int bad, first;
    logic [W-1:0] e, a0;
    if (fr_to === 1'b1 && !fr_q) begin
      n_checks++;
      if (exp_to_q.size() < D) begin
        n_fail++;
        $display("FAIL to_unexpected_frame: got frame with %0d expected words queued, expected %0d", exp_to_q.size(), D);
      end else begin
        bad = 0; first = 0; e = '0; a0 = '0;
        for (int i = 0; i < D; i++) begin
          logic [W-1:0] x;
          x = exp_to_q.pop_front();
          if (fd_to[i] !== x) begin
            if (bad == 0) begin first = i; e = x; a0 = fd_to[i]; end
            bad++;
          end
        end
        if (bad != 0) begin
          n_fail++;
          $display("FAIL to_frame: %0d words differ, first [%0d] got %0d expected %0d", bad, first, a0, e);
        end
      end
    end
    fr_q = (fr_to === 1'b1);
  end

  initial begin
    int busy_drop;
    rst = 1'b1; arm = 1'b0; arm_to = 1'b0; sample_valid = 1'b0; sample = '0;
    trig_level = 16'd2048; trig_slope = 1'b0;
    #2 rst = 1'b0;
    tick(); tick();
    chk("rst_frame_ready", fr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_nonzero", nonzero_main(), 0);

    // Rising trigger, arm on the first cycle after reset release
    rst = 1'b1; arm = 1'b1; tick(); arm = 1'b0;
    chk("arm_busy", busy, 1);
    for (int i = 0; i < D; i++) exp_q.push_back(W'(2048 + 16 * i));
    for (int k = 0; k < 384; k++) begin
      feed(1'b1, W'(16 * k));
      if (k == 382) begin
        chk("rise_ready_early", fr, 0);
        chk("rise_busy_capture", busy, 1);
      end
    end
    sample_valid = 1'b0;
    chk("rise_ready", fr, 1);
    chk("rise_busy_done", busy, 0);
    chk("rise_fd0", fd[0], 2048);
    chk("rise_fd255", fd[255], 6128);

    // Falling trigger with 50% valid gaps; level/slope changed mid-capture
    trig_slope = 1'b1; trig_level = 16'd1000;
    arm = 1'b1; tick(); arm = 1'b0;
    chk("rearm_ready_clear", fr, 0);
    chk("rearm_keeps_fd0", fd[0], 2048);
    frame_a[0] = 16'd1000;
    for (int j = 1; j < D; j++) frame_a[j] = W'(1000 + 3 * j);
    for (int j = 0; j < D; j++) exp_q.push_back(frame_a[j]);
    feed(1'b1, 16'd1200); feed(1'b1, 16'd1100); feed(1'b1, 16'd1000);
    busy_drop = 0;
    for (int j = 1; j < D; j++) begin
      if (j == 128) begin trig_level = 16'd1600; trig_slope = 1'b0; end
      feed(1'b0, 16'hFFFF);
      if (busy !== 1'b1) busy_drop++;
      if (j == 255) chk("fall_ready_early", fr, 0);
      feed(1'b1, W'(1000 + 3 * j));
      if (j < 255 && busy !== 1'b1) busy_drop++;
    end
    sample_valid = 1'b0;
    chk("fall_ready", fr, 1);
    chk("fall_busy_drops", busy_drop, 0);
    chk("fall_fd0", fd[0], 1000);

    // Double buffer: frame B in progress must not disturb frame A
    trig_slope = 1'b0; trig_level = 16'd2048;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < D; i++) exp_q.push_back(W'(3000 + i));
    feed(1'b1, 16'd0);
    for (int i = 0; i < 100; i++) feed(1'b1, W'(3000 + i));
    chk("dbuf_frame_a_held", diff_frame_a(), 0);
    chk("dbuf_ready", fr, 0);
    chk("dbuf_busy", busy, 1);

    // Arm pulse during CAPTURE is ignored
    arm = 1'b1; feed(1'b1, 16'd3100); arm = 1'b0;
    chk("ign_arm_busy", busy, 1);
    for (int i = 101; i < D; i++) begin
      feed(1'b1, W'(3000 + i));
      if (i == 254) chk("ign_ready_early", fr, 0);
    end
    sample_valid = 1'b0;
    chk("ign_ready", fr, 1);

    // Reset mid-capture
    arm = 1'b1; tick(); arm = 1'b0;
    feed(1'b1, 16'd0);
    for (int i = 0; i < 10; i++) feed(1'b1, W'(2500 + i));
    sample_valid = 1'b0;
    rst = 1'b0; #2;
    chk("midrst_frame_nonzero", nonzero_main(), 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", fr, 0);
    tick();
    rst = 1'b1;
    feed(1'b1, 16'd0); feed(1'b1, 16'd4000); feed(1'b1, 16'd0);
    chk("idle_no_arm_busy", busy, 0);
    chk("idle_no_arm_ready", fr, 0);
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < D; i++) exp_q.push_back(W'(2100 + i));
    feed(1'b1, 16'd0);
    for (int i = 0; i < D; i++) begin
      feed(1'b1, W'(2100 + i));
      if (i == 254) chk("postrst_ready_early", fr, 0);
    end
    sample_valid = 1'b0;
    chk("postrst_ready", fr, 1);

    // Auto-trigger after 64 ARMED cycles on the short-timeout instance
    trig_level = 16'd2048; trig_slope = 1'b0;
    arm_to = 1'b1; tick(); arm_to = 1'b0;
    chk("to_arm_busy", busy_to, 1);
    for (int i = 0; i < D; i++) exp_to_q.push_back(16'd100);
    for (int k = 1; k <= 320; k++) begin
      feed(1'b1, 16'd100);
      if (k == 64) chk("to_not_done", fr_to, 0);
      if (k == 319) chk("to_ready_early", fr_to, 0);
    end
    sample_valid = 1'b0;
    chk("to_ready", fr_to, 1);
    chk("to_busy_done", busy_to, 0);

    tick(); tick();
    chk("exp_queues_drained", exp_q.size() + exp_to_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
